// File: rtl/alu_exec_ctrl_pkg.sv
// Shared constants for the ALU execute-stage controller: widths, opcodes,
// NZCV bit positions and FSM state encoding.
package alu_exec_ctrl_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned OP_W      = 3;
  localparam int unsigned NZCV_W    = 4;
  localparam int unsigned ST_W      = 2;

  // Opcodes are forwarded untouched; names document the ALU one level up.
  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_NOT = 3'd5;
  localparam logic [OP_W-1:0] OP_SHL = 3'd6;
  localparam logic [OP_W-1:0] OP_SHR = 3'd7;

  localparam int unsigned N_BIT = 3;
  localparam int unsigned Z_BIT = 2;
  localparam int unsigned C_BIT = 1;
  localparam int unsigned V_BIT = 0;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_EXEC = 2'd1;
  localparam logic [ST_W-1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Request/response handshake bundle between the issuing stage (master)
// and the execute controller (slave).
interface alu_exec_ctrl_if #(
  parameter int unsigned WIDTH = alu_exec_ctrl_pkg::DEF_WIDTH
);
  logic                                   req_valid;
  logic                                   req_ready;
  logic [alu_exec_ctrl_pkg::OP_W-1:0]     req_op;
  logic [WIDTH-1:0]                       req_a;
  logic [WIDTH-1:0]                       req_b;
  logic                                   req_use_acc;
  logic                                   req_flag_we;
  logic                                   rsp_valid;
  logic                                   rsp_ready;
  logic [WIDTH-1:0]                       rsp_result;
  logic [alu_exec_ctrl_pkg::NZCV_W-1:0]   rsp_nzcv;

  modport master (
    output req_valid, req_op, req_a, req_b, req_use_acc, req_flag_we, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_nzcv
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_use_acc, req_flag_we, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_nzcv
  );
endinterface

// File: rtl/alu_exec_ctrl_nzcv_reg.sv
// Architectural NZCV flag register with write enable.
module alu_exec_ctrl_nzcv_reg
  import alu_exec_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [NZCV_W-1:0] d,
  output logic [NZCV_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (we) q <= d;
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: registers ALU operands, captures the ALU result
// and NZCV one cycle later, and holds the accumulator and flag register.
module alu_exec_ctrl
  import alu_exec_ctrl_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst,
  alu_exec_ctrl_if.slave    bus,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic [NZCV_W-1:0] alu_nzcv,
  output logic [WIDTH-1:0]  acc_q,
  output logic [NZCV_W-1:0] flags_q,
  output logic              busy
);

  logic [ST_W-1:0]   state_q;
  logic [ST_W-1:0]   state_d;
  logic              req_ready_c;
  logic              accept;
  logic              exec_fire;
  logic              flag_we_q;
  logic              rsp_valid_q;
  logic [WIDTH-1:0]  rsp_result_q;
  logic [NZCV_W-1:0] rsp_nzcv_q;

  // A response slot frees up on the same edge it retires, so RESP can accept.
  assign req_ready_c    = (state_q == ST_IDLE) | ((state_q == ST_RESP) & bus.rsp_ready);
  assign accept         = bus.req_valid & req_ready_c;
  assign exec_fire      = (state_q == ST_EXEC);
  assign bus.req_ready  = req_ready_c;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_nzcv   = rsp_nzcv_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.req_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_d = bus.req_valid ? ST_EXEC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs are registered copies of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rsp_valid_q <= (state_d == ST_RESP);
      busy        <= (state_d != ST_IDLE);
    end
  end

  // Operand launch on accept; acc_q already holds the prior EXEC result here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      flag_we_q <= 1'b0;
    end else if (accept) begin
      alu_a     <= bus.req_use_acc ? acc_q : bus.req_a;
      alu_b     <= bus.req_b;
      alu_op    <= bus.req_op;
      flag_we_q <= bus.req_flag_we;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_result_q <= '0;
      rsp_nzcv_q   <= '0;
      acc_q        <= ACC_RESET;
    end else if (exec_fire) begin
      rsp_result_q <= alu_result;
      rsp_nzcv_q   <= alu_nzcv;
      acc_q        <= alu_result;
    end
  end

  alu_exec_ctrl_nzcv_reg u_flags (
    .clk (clk),
    .rst (rst),
    .we  (exec_fire & flag_we_q),
    .d   (alu_nzcv),
    .q   (flags_q)
  );

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a stub ALU (add/sub/xor) one level up.
module tb_alu_exec_ctrl;
  import alu_exec_ctrl_pkg::*;

  localparam int unsigned W = 8;
  localparam logic [W-1:0] ACC_INIT = 8'h5A;

  logic          clk;
  logic          rst;
  logic [W-1:0]  alu_a, alu_b, alu_result, acc_q;
  logic [2:0]    alu_op;
  logic [3:0]    alu_nzcv, flags_q;
  logic          busy;

  int checks = 0;
  int errors = 0;

  alu_exec_ctrl_if #(.WIDTH(W)) bus ();

  alu_exec_ctrl #(.WIDTH(W), .ACC_RESET(ACC_INIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_nzcv   (alu_nzcv),
    .acc_q      (acc_q),
    .flags_q    (flags_q),
    .busy       (busy)
  );

  // Stub ALU: add/sub with ARM-style carry (C = no borrow on sub), else xor.
  function automatic logic [11:0] stub_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] t;
    logic [7:0] r;
    logic       c;
    logic       v;
    t = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD: begin
        t = {1'b0, a} + {1'b0, b};
        r = t[7:0]; c = t[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      OP_SUB: begin
        t = {1'b0, a} - {1'b0, b};
        r = t[7:0]; c = ~t[8];
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      default: r = a ^ b;
    endcase
    return {r[7], (r == 8'h00), c, v, r};
  endfunction

  assign {alu_nzcv, alu_result} = stub_alu(alu_op, alu_a, alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic use_acc, input logic we);
    bus.req_valid   = 1'b1;
    bus.req_op      = op;
    bus.req_a       = a;
    bus.req_b       = b;
    bus.req_use_acc = use_acc;
    bus.req_flag_we = we;
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       use_acc;
    logic       we;
    logic [7:0] exp_a;
    logic [7:0] exp_res;
    logic [3:0] exp_nzcv;
    logic [3:0] exp_flags;
  } vec_t;

  vec_t vecs[6];

  initial begin
    // op, a, b, use_acc, we, expected alu_a, result, nzcv, flags after
    vecs[0] = '{3'd0, 8'h05, 8'h03, 1'b0, 1'b1, 8'h05, 8'h08, 4'b0000, 4'b0000};
    vecs[1] = '{3'd0, 8'h7F, 8'h01, 1'b0, 1'b1, 8'h7F, 8'h80, 4'b1001, 4'b1001};
    vecs[2] = '{3'd1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 4'b0110, 4'b1001};
    vecs[3] = '{3'd1, 8'hAA, 8'h01, 1'b1, 1'b1, 8'h00, 8'hFF, 4'b1000, 4'b1000};
    vecs[4] = '{3'd0, 8'h11, 8'h02, 1'b1, 1'b1, 8'hFF, 8'h01, 4'b0010, 4'b0010};
    vecs[5] = '{3'd5, 8'h3C, 8'h0F, 1'b0, 1'b0, 8'h3C, 8'h33, 4'b0000, 4'b0010};

    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
    bus.req_use_acc = 1'b0; bus.req_flag_we = 1'b0; bus.rsp_ready = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset acc_q", 32'(acc_q), 32'(ACC_INIT));
    check("reset flags_q", 32'(flags_q), 32'h0);
    check("reset alu_a", 32'(alu_a), 32'h0);
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset req_ready", 32'(bus.req_ready), 32'h1);

    // Table-driven single operations, one full transaction each.
    for (int i = 0; i < 6; i++) begin
      drive_req(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].use_acc, vecs[i].we);
      check($sformatf("v%0d req_ready idle", i), 32'(bus.req_ready), 32'h1);
      @(negedge clk);
      bus.req_valid = 1'b0;
      check($sformatf("v%0d alu_a", i), 32'(alu_a), 32'(vecs[i].exp_a));
      check($sformatf("v%0d alu_b", i), 32'(alu_b), 32'(vecs[i].b));
      check($sformatf("v%0d alu_op", i), 32'(alu_op), 32'(vecs[i].op));
      check($sformatf("v%0d rsp_valid exec", i), 32'(bus.rsp_valid), 32'h0);
      @(negedge clk);
      check($sformatf("v%0d rsp_valid", i), 32'(bus.rsp_valid), 32'h1);
      check($sformatf("v%0d rsp_result", i), 32'(bus.rsp_result), 32'(vecs[i].exp_res));
      check($sformatf("v%0d rsp_nzcv", i), 32'(bus.rsp_nzcv), 32'(vecs[i].exp_nzcv));
      check($sformatf("v%0d acc_q", i), 32'(acc_q), 32'(vecs[i].exp_res));
      check($sformatf("v%0d flags_q", i), 32'(flags_q), 32'(vecs[i].exp_flags));
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check($sformatf("v%0d idle busy", i), 32'(busy), 32'h0);
    end

    // Stall: response held while rsp_ready is low; a pending request must wait.
    drive_req(OP_ADD, 8'hFF, 8'h01, 1'b0, 1'b1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("stall exec busy", 32'(busy), 32'h1);
    check("stall exec req_ready", 32'(bus.req_ready), 32'h0);
    for (int k = 0; k < 4; k++) begin
      if (k == 1) drive_req(OP_SUB, 8'h11, 8'h22, 1'b0, 1'b0);
      @(negedge clk);
      check($sformatf("stall%0d rsp_valid", k), 32'(bus.rsp_valid), 32'h1);
      check($sformatf("stall%0d rsp_result", k), 32'(bus.rsp_result), 32'h00);
      check($sformatf("stall%0d rsp_nzcv", k), 32'(bus.rsp_nzcv), 32'b0110);
      check($sformatf("stall%0d req_ready", k), 32'(bus.req_ready), 32'h0);
      check($sformatf("stall%0d busy", k), 32'(busy), 32'h1);
      check($sformatf("stall%0d alu_a held", k), 32'(alu_a), 32'hFF);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("stall release rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("stall release busy", 32'(busy), 32'h0);
    check("stall flags_q", 32'(flags_q), 32'b0110);
    check("stall acc_q", 32'(acc_q), 32'h00);

    // Asynchronous reset mid-cycle, no clock edge in between.
    #2 rst = 1'b1;
    #1;
    check("async acc_q", 32'(acc_q), 32'(ACC_INIT));
    check("async flags_q", 32'(flags_q), 32'h0);
    check("async alu_a", 32'(alu_a), 32'h0);
    check("async alu_b", 32'(alu_b), 32'h0);
    check("async rsp_nzcv", 32'(bus.rsp_nzcv), 32'h0);
    check("async req_ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back chain: second op takes acc_q from the first.
    bus.rsp_ready = 1'b1;
    drive_req(OP_ADD, 8'h10, 8'h20, 1'b0, 1'b1);
    @(negedge clk);
    drive_req(OP_SUB, 8'h00, 8'h40, 1'b1, 1'b1);
    check("chain1 alu_a", 32'(alu_a), 32'h10);
    @(negedge clk);
    check("chain1 rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("chain1 rsp_result", 32'(bus.rsp_result), 32'h30);
    check("chain1 req_ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("chain2 rsp_valid gap", 32'(bus.rsp_valid), 32'h0);
    check("chain2 alu_a bypass", 32'(alu_a), 32'h30);
    check("chain2 alu_op", 32'(alu_op), 32'(OP_SUB));
    @(negedge clk);
    check("chain2 rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("chain2 rsp_result", 32'(bus.rsp_result), 32'hF0);
    check("chain2 rsp_nzcv", 32'(bus.rsp_nzcv), 32'b1000);
    check("chain2 acc_q", 32'(acc_q), 32'hF0);
    check("chain2 flags_q", 32'(flags_q), 32'b1000);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("chain idle busy", 32'(busy), 32'h0);

    // Reset while in EXEC drops the in-flight operation.
    drive_req(OP_ADD, 8'h01, 8'h01, 1'b0, 1'b1);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rexec busy", 32'(busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("rexec rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rexec busy after", 32'(busy), 32'h0);
    check("rexec acc_q", 32'(acc_q), 32'(ACC_INIT));
    check("rexec flags_q", 32'(flags_q), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rexec no response", 32'(bus.rsp_valid), 32'h0);
    check("rexec acc held", 32'(acc_q), 32'(ACC_INIT));
    bus.rsp_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
